// File: rtl/seg7_pkg.sv
// Shared segment encodings for the 7-segment display path.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  localparam logic [0:15][6:0] SEG_TABLE = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0100111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  function automatic logic [6:0] seg7_dec(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-high segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = seg7_dec(nibble_i);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver with frame-synchronous
// value updates, leading-zero blanking and per-slot anti-ghost gap.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned BLANK_CYC   = 500,
  parameter int unsigned SEG_ACT_LOW = 0,
  parameter int unsigned DIG_ACT_LOW = 1,
  parameter int unsigned LZ_BLANK    = 1
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_tick
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(SCAN_DIV);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_IDLE  = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_IDLE   = (SEG_ACT_LOW != 0);
  localparam logic [DIGITS-1:0] DIG_IDLE  = (DIG_ACT_LOW != 0) ? '1 : '0;

  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [4*DIGITS-1:0] shadow_q, pend_q;
  logic [DIGITS-1:0]   shadow_dp_q, pend_dp_q;
  logic                pend_v_q;
  logic                tick_q;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic [DIGITS-1:0]   dig_en_q;

  logic                wrap;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_lz;
  logic                on;
  logic                zero_run;
  logic [DIGITS-1:0]   lz_vec;
  logic [DIGITS-1:0]   dig_on;
  logic [6:0]          dec_seg;
  logic [6:0]          seg_d;
  logic                dp_d;
  logic [DIGITS-1:0]   dig_en_d;

  assign wrap = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

  // Walk from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    zero_run = 1'b1;
    lz_vec   = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      zero_run = zero_run && (shadow_q[(DIGITS-1-k)*4 +: 4] == 4'h0);
      lz_vec[DIGITS-1-k] = zero_run && (LZ_BLANK != 0) && (k != DIGITS-1);
    end
  end

  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib = shadow_q[k*4 +: 4];
        cur_dp  = shadow_dp_q[k];
        cur_lz  = lz_vec[k];
      end
    end
  end

  seg7_decode u_decode (
    .nibble_i (cur_nib),
    .seg_o    (dec_seg)
  );

  always_comb begin
    on     = (cnt_q >= CNT_BLANK) && !blank && !cur_lz;
    dig_on = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      dig_on[k] = on && (idx_q == IDX_W'(k));
    end
    seg_d    = (on ? dec_seg : SEG_OFF) ^ SEG_IDLE;
    dp_d     = (on && cur_dp) ^ DP_IDLE;
    dig_en_d = dig_on ^ DIG_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      pend_q      <= '0;
      pend_dp_q   <= '0;
      pend_v_q    <= 1'b0;
      tick_q      <= 1'b0;
      seg_q       <= SEG_IDLE;
      dp_q        <= DP_IDLE;
      dig_en_q    <= DIG_IDLE;
    end else begin
      tick_q <= wrap;
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      // A load coinciding with the wrap bypasses pending entirely.
      if (load && wrap) begin
        shadow_q    <= value;
        shadow_dp_q <= dp_in;
        pend_v_q    <= 1'b0;
      end else if (load) begin
        pend_q    <= value;
        pend_dp_q <= dp_in;
        pend_v_q  <= 1'b1;
      end else if (wrap && pend_v_q) begin
        shadow_q    <= pend_q;
        shadow_dp_q <= pend_dp_q;
        pend_v_q    <= 1'b0;
      end

      seg_q    <= seg_d;
      dp_q     <= dp_d;
      dig_en_q <= dig_en_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig_en     = dig_en_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a 4-digit, 4-cycle-slot scan.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig_en;
  logic        frame_tick;

  int unsigned total = 0;
  int unsigned bad   = 0;

  seg7_scan_driver #(
    .DIGITS      (4),
    .SCAN_DIV    (4),
    .BLANK_CYC   (1),
    .SEG_ACT_LOW (0),
    .DIG_ACT_LOW (0),
    .LZ_BLANK    (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .blank      (blank),
    .seg        (seg),
    .dp         (dp),
    .dig_en     (dig_en),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for frame_tick with a cycle budget; returns cycles taken.
  task automatic wait_tick(output int unsigned n);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_tick && n < 40);
    check("tick_seen", {31'd0, frame_tick}, 32'd1);
  endtask

  // Checks one full frame starting right after a frame_tick cycle.
  task automatic run_frame(input logic [6:0] s3, input logic [6:0] s2,
                           input logic [6:0] s1, input logic [6:0] s0,
                           input logic [3:0] dpx, input logic [3:0] lit,
                           input int ld_slot, input logic [15:0] lv,
                           input logic [3:0] ldp);
    logic [6:0] s [4];
    s = '{s0, s1, s2, s3};
    for (int j = 0; j < 16; j++) begin
      int d;
      d = j / 4;
      if (j == ld_slot) begin
        value = lv;
        dp_in = ldp;
        load  = 1'b1;
      end
      step();
      load = 1'b0;
      if (j % 4 == 0) begin
        check("ghost_gap", {28'd0, dig_en}, 32'd0);
      end else begin
        check("dig_en", {28'd0, dig_en}, lit[d] ? (32'd1 << d) : 32'd0);
        check("seg", {25'd0, seg}, lit[d] ? {25'd0, s[d]} : 32'd0);
        check("dp", {31'd0, dp}, lit[d] ? {31'd0, dpx[d]} : 32'd0);
      end
      check("tick", {31'd0, frame_tick}, (j == 15) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int unsigned n;
    rst   = 1'b0;
    value = '0;
    dp_in = '0;
    load  = 1'b0;
    blank = 1'b0;
    repeat (3) step();
    check("rst_seg", {25'd0, seg}, 32'd0);
    check("rst_dp", {31'd0, dp}, 32'd0);
    check("rst_dig_en", {28'd0, dig_en}, 32'd0);
    check("rst_tick", {31'd0, frame_tick}, 32'd0);

    rst = 1'b1;
    step();
    check("rel_c1_dig_en", {28'd0, dig_en}, 32'd0);
    step();
    check("rel_c2_dig_en", {28'd0, dig_en}, 32'd1);
    check("rel_c2_seg", {25'd0, seg}, 32'h3F);

    wait_tick(n);
    check("first_tick_at", n, 32'd14);
    wait_tick(n);
    check("tick_period", n, 32'd16);

    // Mid-frame load: current frame unchanged, next frame shows 12AF.
    run_frame(7'b0, 7'b0, 7'b0, 7'b0111111, 4'b0000, 4'b0001, 6, 16'h12AF, 4'b0100);
    run_frame(7'b0000110, 7'b1011011, 7'b1110111, 7'b1110001, 4'b0100, 4'b1111, -1, '0, '0);

    // Leading zeros.
    run_frame(7'b0000110, 7'b1011011, 7'b1110111, 7'b1110001, 4'b0100, 4'b1111, 9, 16'h0005, 4'b0000);
    run_frame(7'b0, 7'b0, 7'b0, 7'b1101101, 4'b0000, 4'b0001, 3, 16'h0000, 4'b0000);

    // Blank forces all dark while the scan keeps ticking.
    blank = 1'b1;
    run_frame(7'b0, 7'b0, 7'b0, 7'b0, 4'b0000, 4'b0000, -1, '0, '0);
    blank = 1'b0;

    // Load on the wrap cycle goes straight to the display.
    run_frame(7'b0, 7'b0, 7'b0, 7'b0111111, 4'b0000, 4'b0001, 15, 16'h3C00, 4'b0000);
    run_frame(7'b1001111, 7'b0111001, 7'b0111111, 7'b0111111, 4'b0000, 4'b1111, -1, '0, '0);
    run_frame(7'b1001111, 7'b0111001, 7'b0111111, 7'b0111111, 4'b0000, 4'b1111, -1, '0, '0);

    // Reset mid-frame discards a pending BEEF.
    value = 16'hBEEF;
    dp_in = 4'b1111;
    load  = 1'b1;
    step();
    load = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
    check("mrst_dig_en", {28'd0, dig_en}, 32'd0);
    rst = 1'b1;
    step();
    check("mrst_c1_dig_en", {28'd0, dig_en}, 32'd0);
    step();
    check("mrst_c2_dig_en", {28'd0, dig_en}, 32'd1);
    check("mrst_c2_seg", {25'd0, seg}, 32'h3F);
    wait_tick(n);
    check("mrst_tick_at", n, 32'd14);
    run_frame(7'b0, 7'b0, 7'b0, 7'b0111111, 4'b0000, 4'b0001, -1, '0, '0);
    run_frame(7'b0, 7'b0, 7'b0, 7'b0111111, 4'b0000, 4'b0001, -1, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Multi-digit, time-multiplexed 7-segment display driver; successor to the single-digit registered hex decoder.
- Latches a packed hex word, scans DIGITS common-anode/cathode digits round-robin, decodes nibbles to segments, and adds decimal points, leading-zero blanking and anti-ghosting.
- Sits between a value source (UART receive path, counters) and the board display pins.
- Display updates are frame-synchronous, so the display never shows a partial value.

Parameters:
- DIGITS, 4: number of digits scanned; must be at least 1. Digit 0 is the rightmost, least-significant nibble.
- SCAN_DIV, 50000: clk cycles per digit slot; must be at least 2.
- BLANK_CYC, 500: cycles at the start of each slot with all digit enables off (anti-ghost); must be less than SCAN_DIV.
- SEG_ACT_LOW, 0: 1 inverts the seg and dp outputs.
- DIG_ACT_LOW, 1: 1 inverts the dig_en outputs.
- LZ_BLANK, 1: 1 enables leading-zero blanking.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- value  in  4*DIGITS  packed hex digits; nibble i is digit i
- dp_in  in  DIGITS  decimal-point request per digit
- load  in  1  single-cycle strobe that captures value and dp_in
- blank  in  1  level input; 1 forces all digits dark
- seg  out  7  segments {g,f,e,d,c,b,a}, registered
- dp  out  1  decimal point, registered
- dig_en  out  DIGITS  one-hot digit enable, registered
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to 0

Behaviour:
- Reset (rst=0 at a clk edge) clears:
  - slot counter cnt and digit index idx to 0
  - shadow and pending registers to 0; pend_v to 0
  - frame_tick to 0
  - seg and dp to the inactive level: 0, or all 1 if SEG_ACT_LOW
  - dig_en to all inactive
  - Reset mid-frame discards any pending load.
- Slot counter:
  - cnt increments every cycle.
  - When cnt==SCAN_DIV-1: cnt goes to 0 and idx advances, wrapping from DIGITS-1 to 0.
  - wrap = (cnt==SCAN_DIV-1 && idx==DIGITS-1).
  - frame_tick is registered and high for the one cycle after the wrap edge.
- Load path:
  - load=1 captures value and dp_in into pending and sets pend_v.
  - On wrap with pend_v=1: shadow takes pending, pend_v clears.
  - If load and wrap occur in the same cycle, the new value and dp_in go straight to shadow and pend_v clears.
  - Multiple loads within one frame: the last one wins.
  - Decoding always reads shadow, never value.
- Decode table (hex to {g..a}):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0100111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- Leading-zero blanking: digit i>0 is blank when LZ_BLANK=1 and shadow nibbles i through DIGITS-1 are all 0. Digit 0 is never LZ-blanked, so 0 displays as "0".
- Output register, computed each cycle from the current idx and cnt, visible one cycle later:
  - on = (cnt >= BLANK_CYC) && !blank && !lzblank(idx).
  - dig_en: bit idx active when on; all other bits inactive.
  - seg = decode(shadow nibble idx) when on, else all off.
  - dp = shadow dp[idx] when on, else off.
  - Polarity inversion is applied last, per SEG_ACT_LOW and DIG_ACT_LOW.
- blank does not stop the counter or suppress frame_tick.
- DIGITS=1: idx stays 0 and wrap occurs every SCAN_DIV cycles.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry segment constant table
  - the all-off segment constant
  - a pure function decoding a nibble to segments
- Sub-module seg7_decode: combinational nibble to 7-bit segments, one instance muxed by idx.
- Counter, load/shadow logic and output register stay in the top module.

Test Plan (DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, SEG_ACT_LOW=0, DIG_ACT_LOW=0, LZ_BLANK=1):
- Reset:
  - Hold rst=0 for 3 cycles -> seg=0, dp=0, dig_en=0000, frame_tick=0.
  - Release -> first active output dig_en=0001 at cycle 2 after release; frame_tick pulses every 16 cycles.
- Load and decode:
  - load value=16'h12AF, dp_in=4'b0100 mid-frame -> display unchanged (digit 0 shows "0") until the next frame_tick.
  - Following frame shows:
    - digit0 seg=1110001
    - digit1 seg=1110111
    - digit2 seg=1011011, dp=1
    - digit3 seg=0000110
- Leading zeros: load 16'h0005 -> digits 3..1 show dig_en=0000 and seg=0 in their slots; digit0 shows seg=1101101. Load 16'h0000 -> only digit0 lit, showing 0111111.
- Anti-ghost and blank:
  - Every slot shows exactly 1 cycle with dig_en=0000 before its digit lights.
  - blank=1 -> all outputs off, but frame_tick keeps its 16-cycle period.
- Coincident load and wrap: assert load=16'h3C00 exactly on the wrap cycle -> the very next frame shows 3C00 (digit3=1001111, digit2=0111001); pend_v=0 afterwards.
- Reset mid-operation: load 16'hBEEF, then pulse rst=0 before the wrap -> after release the display shows 0 and BEEF never appears.
